// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the machine-mode interrupt controller: CSR addresses,
// cause codes, CSR bit positions and the handshake FSM encoding.
package irq_ctrl_pkg;

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMie     = 12'h304;
   localparam logic [11:0] CsrMcause  = 12'h342;
   localparam logic [11:0] CsrMip     = 12'h344;

   localparam logic [3:0] CauseSw  = 4'd3;
   localparam logic [3:0] CauseTmr = 4'd7;
   localparam logic [3:0] CauseExt = 4'd11;

   // Source bit positions in mip/mie
   localparam int unsigned SwBit  = 3;
   localparam int unsigned TmrBit = 7;
   localparam int unsigned ExtBit = 11;

   // mstatus bit positions
   localparam int unsigned MieBit  = 3;
   localparam int unsigned MpieBit = 7;

   localparam logic [31:0] MieMask = 32'h0000_0888;

   // Packed pending vector layout used by the priority encoder
   localparam int unsigned PendSw  = 0;
   localparam int unsigned PendTmr = 1;
   localparam int unsigned PendExt = 2;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StTrap
   } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for the three machine interrupt sources:
// external > software > timer.
module irq_prio_enc
   import irq_ctrl_pkg::*;
(
   input  logic [2:0] pend,
   output logic       valid,
   output logic [3:0] code
);

   always_comb begin
      valid = |pend;
      code  = 4'd0;
      if (pend[PendExt]) begin
         code = CauseExt;
      end else if (pend[PendSw]) begin
         code = CauseSw;
      end else if (pend[PendTmr]) begin
         code = CauseTmr;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mstatus/mie/mip/mcause CSRs, source
// arbitration and the request/acknowledge handshake. Define IRQ_EXT_SYNC_EN
// to pass external_interrupt through a 2-flop synchronizer.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned MCAUSE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                timer_interrupt,
   input  logic                software_interrupt,
   input  logic                external_interrupt,
   input  logic [11:0]         csr_addr,
   input  logic [31:0]         csr_wdata,
   input  logic                csr_we,
   input  logic                csr_re,
   output logic [31:0]         csr_rdata,
   output logic                csr_valid,
   output logic                irq_req,
   output logic [MCAUSE_W-1:0] irq_cause,
   input  logic                irq_ack,
   input  logic                mret
);

   irq_state_e          state_q, state_d;
   logic                req_q, req_d;
   logic [MCAUSE_W-1:0] cause_q, cause_d;
   logic [MCAUSE_W-1:0] mcause_q, mcause_d;
   logic [31:0]         mie_q, mie_d;
   logic                mstatus_mie_q, mstatus_mie_d;
   logic                mpie_q, mpie_d;

   logic                ext_lvl;
   logic [31:0]         mip;
   logic [2:0]          pend;
   logic                pend_valid;
   logic [3:0]          pend_code;
   logic [MCAUSE_W-1:0] cause_new;
   logic                ack_take;

`ifdef IRQ_EXT_SYNC_EN
   logic ext_s1_q, ext_s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_s1_q <= 1'b0;
         ext_s2_q <= 1'b0;
      end else begin
         ext_s1_q <= external_interrupt;
         ext_s2_q <= ext_s1_q;
      end
   end

   assign ext_lvl = ext_s2_q;
`else
   assign ext_lvl = external_interrupt;
`endif

   always_comb begin
      mip         = 32'b0;
      mip[ExtBit] = ext_lvl;
      mip[TmrBit] = timer_interrupt;
      mip[SwBit]  = software_interrupt;
   end

   // Qualified pending: live level, enabled in mie, globally gated by MIE
   assign pend[PendExt] = mip[ExtBit] & mie_q[ExtBit] & mstatus_mie_q;
   assign pend[PendTmr] = mip[TmrBit] & mie_q[TmrBit] & mstatus_mie_q;
   assign pend[PendSw]  = mip[SwBit]  & mie_q[SwBit]  & mstatus_mie_q;

   irq_prio_enc u_prio_enc (
      .pend  (pend),
      .valid (pend_valid),
      .code  (pend_code)
   );

   assign cause_new = {1'b1, {(MCAUSE_W-5){1'b0}}, pend_code};
   assign ack_take  = (state_q == StReq) && irq_ack;

   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      cause_d       = cause_q;
      mcause_d      = mcause_q;
      mie_d         = mie_q;
      mstatus_mie_d = mstatus_mie_q;
      mpie_d        = mpie_q;

      // Software CSR writes have the lowest priority; hardware events below override.
      if (csr_we) begin
         unique case (csr_addr)
            CsrMstatus: begin
               mstatus_mie_d = csr_wdata[MieBit];
               mpie_d        = csr_wdata[MpieBit];
            end
            CsrMie:    mie_d    = csr_wdata & MieMask;
            CsrMcause: mcause_d = MCAUSE_W'(csr_wdata);
            default: ;
         endcase
      end

      if (ack_take) begin
         mcause_d      = cause_q;
         mpie_d        = mstatus_mie_q;
         mstatus_mie_d = 1'b0;
         req_d         = 1'b0;
         state_d       = StTrap;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pend_valid) begin
                  state_d = StReq;
                  req_d   = 1'b1;
                  cause_d = cause_new;
               end
            end
            StReq: begin
               if (!pend_valid) begin
                  state_d = StIdle;
                  req_d   = 1'b0;
               end else begin
                  cause_d = cause_new;
               end
            end
            StTrap:  req_d = 1'b0;
            default: begin
               state_d = StIdle;
               req_d   = 1'b0;
            end
         endcase

         if (mret) begin
            mstatus_mie_d = mpie_q;
            mpie_d        = 1'b1;
            // Leaving TRAP, or MIE about to clear: no request may stand
            if (state_q == StTrap || !mpie_q) begin
               state_d = StIdle;
               req_d   = 1'b0;
               cause_d = cause_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         req_q         <= 1'b0;
         cause_q       <= '0;
         mcause_q      <= '0;
         mie_q         <= 32'b0;
         mstatus_mie_q <= 1'b0;
         mpie_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         cause_q       <= cause_d;
         mcause_q      <= mcause_d;
         mie_q         <= mie_d;
         mstatus_mie_q <= mstatus_mie_d;
         mpie_q        <= mpie_d;
      end
   end

   assign irq_req   = req_q;
   assign irq_cause = cause_q;

   assign csr_valid = (csr_addr == CsrMstatus) || (csr_addr == CsrMie) ||
                      (csr_addr == CsrMcause)  || (csr_addr == CsrMip);

   always_comb begin
      csr_rdata = 32'b0;
      if (csr_re && csr_valid) begin
         unique case (csr_addr)
            CsrMstatus: begin
               csr_rdata[12:11]   = 2'b11;
               csr_rdata[MpieBit] = mpie_q;
               csr_rdata[MieBit]  = mstatus_mie_q;
            end
            CsrMie:    csr_rdata = mie_q;
            CsrMcause: csr_rdata = 32'(mcause_q);
            CsrMip:    csr_rdata = mip;
            default:   csr_rdata = 32'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed handshake scenarios, then randomized traffic
// checked cycle by cycle against a behavioural model of the controller.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        timer_interrupt, software_interrupt, external_interrupt;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic        csr_we, csr_re;
   logic [31:0] csr_rdata;
   logic        csr_valid;
   logic        irq_req;
   logic [31:0] irq_cause;
   logic        irq_ack, mret;

   int checks   = 0;
   int failures = 0;

   irq_ctrl #(.MCAUSE_W(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .timer_interrupt    (timer_interrupt),
      .software_interrupt (software_interrupt),
      .external_interrupt (external_interrupt),
      .csr_addr           (csr_addr),
      .csr_wdata          (csr_wdata),
      .csr_we             (csr_we),
      .csr_re             (csr_re),
      .csr_rdata          (csr_rdata),
      .csr_valid          (csr_valid),
      .irq_req            (irq_req),
      .irq_cause          (irq_cause),
      .irq_ack            (irq_ack),
      .mret               (mret)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase 0 = no request, 1 = requesting, 2 = in trap handler
   int          m_phase, n_phase;
   bit          m_gie, n_gie, m_pie, n_pie, m_req, n_req;
   logic [31:0] m_en, n_en, m_mcause, n_mcause, m_cause, n_cause;
   bit          m_s1, m_s2, n_s1, n_s2;

   function automatic bit ext_seen();
`ifdef IRQ_EXT_SYNC_EN
      return m_s2;
`else
      return external_interrupt;
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (32'(m_pie) << 7) | (32'(m_gie) << 3);
         12'h304: return m_en;
         12'h342: return m_mcause;
         12'h344: return (32'(ext_seen()) << 11) | (32'(timer_interrupt) << 7) |
                         (32'(software_interrupt) << 3);
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_next();
      int code;
      code = 0;
      if (m_gie) begin
         if (ext_seen() && m_en[11])                 code = 11;
         else if (software_interrupt && m_en[3])     code = 3;
         else if (timer_interrupt && m_en[7])        code = 7;
      end
      n_phase = m_phase; n_gie = m_gie; n_pie = m_pie; n_req = m_req;
      n_en = m_en; n_mcause = m_mcause; n_cause = m_cause;
      n_s1 = external_interrupt; n_s2 = m_s1;
      if (rst) begin
         n_phase = 0; n_gie = 0; n_pie = 0; n_req = 0;
         n_en = 0; n_mcause = 0; n_cause = 0; n_s1 = 0; n_s2 = 0;
         return;
      end
      if (csr_we && csr_addr == 12'h300) begin n_gie = csr_wdata[3]; n_pie = csr_wdata[7]; end
      if (csr_we && csr_addr == 12'h304) n_en = csr_wdata & 32'h888;
      if (csr_we && csr_addr == 12'h342) n_mcause = csr_wdata;
      if (m_phase == 1 && irq_ack) begin
         n_mcause = m_cause; n_pie = m_gie; n_gie = 0; n_req = 0; n_phase = 2;
      end else begin
         if (m_phase != 2 && code != 0) begin
            n_phase = 1; n_req = 1; n_cause = 32'h8000_0000 + 32'(code);
         end else if (m_phase == 1) begin
            n_phase = 0; n_req = 0;
         end
         if (mret) begin
            n_gie = m_pie; n_pie = 1;
            if (m_phase == 2 || !m_pie) begin n_phase = 0; n_req = 0; n_cause = m_cause; end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      model_next();
      @(posedge clk);
      #1;
      m_phase = n_phase; m_gie = n_gie; m_pie = n_pie; m_req = n_req;
      m_en = n_en; m_mcause = n_mcause; m_cause = n_cause; m_s1 = n_s1; m_s2 = n_s2;
      rst = 0; csr_we = 0; irq_ack = 0; mret = 0;
      chk("model_irq_req", 32'(irq_req), 32'(m_req));
      chk("model_irq_cause", irq_cause, m_cause);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_addr = a; csr_wdata = d; csr_we = 1;
      tick();
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a; csr_re = 1;
      #1;
      chk(tag, csr_rdata, exp);
      chk({tag, "_model"}, csr_rdata, model_read(a));
   endtask

   initial begin
      logic [11:0] addrs [4];
      addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h342; addrs[3] = 12'h344;
      m_phase = 0; m_gie = 0; m_pie = 0; m_req = 0; m_en = 0; m_mcause = 0; m_cause = 0;
      m_s1 = 0; m_s2 = 0;
      rst = 1; timer_interrupt = 0; software_interrupt = 0; external_interrupt = 0;
      csr_addr = 0; csr_wdata = 0; csr_we = 0; csr_re = 1; irq_ack = 0; mret = 0;
      rst = 1;
      tick();

      // Reset state
      chk("rst_req", 32'(irq_req), 32'h0);
      chk("rst_cause", irq_cause, 32'h0);
      rd("rst_mstatus", 12'h300, 32'h1800);
      rd("rst_mie", 12'h304, 32'h0);
      rd("rst_mcause", 12'h342, 32'h0);
      rd("rst_mip", 12'h344, 32'h0);
      rd("unsel_rdata", 12'h305, 32'h0);
      chk("unsel_valid", 32'(csr_valid), 32'h0);
      csr_addr = 12'h344; #1;
      chk("sel_valid", 32'(csr_valid), 32'h1);

      // Timer path
      wr(12'h304, 32'hFFFF_FFFF);
      rd("mie_mask", 12'h304, 32'h888);
      wr(12'h304, 32'h80);
      wr(12'h300, 32'h8);
      timer_interrupt = 1;
      tick();
      chk("tmr_req", 32'(irq_req), 32'h1);
      chk("tmr_cause", irq_cause, 32'h8000_0007);
      irq_ack = 1;
      tick();
      chk("ack_req_low", 32'(irq_req), 32'h0);
      rd("ack_mcause", 12'h342, 32'h8000_0007);
      rd("ack_mstatus", 12'h300, 32'h1880);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("trap_mask", 32'(irq_req), 32'h0);
      end
      mret = 1;
      tick();
      rd("mret_mstatus", 12'h300, 32'h1888);
      chk("mret_same_cycle", 32'(irq_req), 32'h0);
      tick();
      chk("mret_rerequest", 32'(irq_req), 32'h1);

      // Priority
      software_interrupt = 1; external_interrupt = 1;
      wr(12'h304, 32'h888);
      repeat (3) tick();
      chk("prio_ext", irq_cause, 32'h8000_000B);
      external_interrupt = 0;
      repeat (3) tick();
      chk("prio_sw", irq_cause, 32'h8000_0003);

      // Withdrawal
      wr(12'h304, 32'h0);
      tick();
      chk("withdraw_req", 32'(irq_req), 32'h0);
      rd("withdraw_mcause", 12'h342, 32'h8000_0007);
      wr(12'h304, 32'h888);
      tick();
      chk("rerequest_req", 32'(irq_req), 32'h1);
      chk("rerequest_cause", irq_cause, 32'h8000_0003);

      // ack + mret together: trap entry only
      irq_ack = 1; mret = 1;
      tick();
      chk("ackmret_req", 32'(irq_req), 32'h0);
      rd("ackmret_mstatus", 12'h300, 32'h1880);
      rd("ackmret_mcause", 12'h342, 32'h8000_0003);
      mret = 1;
      tick();
      tick();
      chk("ackmret_again", 32'(irq_req), 32'h1);

      // ack + mstatus write together: ack wins
      irq_ack = 1;
      wr(12'h300, 32'h8);
      rd("ackwr_mstatus", 12'h300, 32'h1880);
      mret = 1;
      tick();
      tick();
      chk("ackwr_again", 32'(irq_req), 32'h1);

      // Reset mid-REQ
      rst = 1;
      tick();
      chk("rstreq_req", 32'(irq_req), 32'h0);
      rd("rstreq_mie", 12'h304, 32'h0);
      rd("rstreq_mstatus", 12'h300, 32'h1800);

      // External latency
      timer_interrupt = 0; software_interrupt = 0;
      wr(12'h304, 32'h800);
      wr(12'h300, 32'h8);
      external_interrupt = 1;
`ifdef IRQ_EXT_SYNC_EN
      tick(); chk("ext_lat1", 32'(irq_req), 32'h0);
      tick(); chk("ext_lat2", 32'(irq_req), 32'h0);
      tick(); chk("ext_lat3", 32'(irq_req), 32'h1);
`else
      tick(); chk("ext_lat1", 32'(irq_req), 32'h1);
`endif
      chk("ext_cause", irq_cause, 32'h8000_000B);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) timer_interrupt    = ~timer_interrupt;
         if ($urandom_range(0, 7) == 0) software_interrupt = ~software_interrupt;
         if ($urandom_range(0, 7) == 0) external_interrupt = ~external_interrupt;
         if ($urandom_range(0, 4) == 0) begin
            csr_we    = 1;
            csr_addr  = addrs[$urandom_range(0, 3)];
            csr_wdata = $urandom;
            if (csr_addr == 12'h300 && $urandom_range(0, 2) != 0) csr_wdata[3] = 1'b1;
         end
         irq_ack = ($urandom_range(0, 2) == 0);
         mret    = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         if (mret && csr_we && csr_addr == 12'h300) csr_we = 0;
         rst = ($urandom_range(0, 99) == 0);
         tick();
         csr_addr = addrs[i % 4]; csr_re = 1;
         #1;
         chk("rand_rdata", csr_rdata, model_read(csr_addr));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
